// File: rtl/rv_dmem_responder_pkg.sv
// rv_dmem_responder_pkg: shared types and constants for the dmem responder slice
package rv_dmem_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} t_dmem_state;
  localparam logic [3:0] DMEM_BE_BYTE = 4'b0001;
  localparam logic [3:0] DMEM_BE_HALF = 4'b0011;
  localparam logic [3:0] DMEM_BE_WORD = 4'b1111;
  typedef struct packed {
    logic [3:0]  byte_en;
    logic        sign_ext;
    logic [1:0]  off;
    logic [31:0] wr_data;
  } t_dmem_req;
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } t_dmem_rsp;
endpackage

// File: rtl/rv_dmem_responder_if.sv
// rv_dmem_responder_if: MA-stage dmem request/response bundle
interface rv_dmem_responder_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_rd_en;
  logic              req_wr_en;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wr_data;
  logic [3:0]        req_byte_en;
  logic              req_sign_ext;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rd_data;
  logic              rsp_err;
  modport master(
    output req_valid, req_rd_en, req_wr_en, req_addr, req_wr_data, req_byte_en, req_sign_ext, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd_data, rsp_err
  );
  modport slave(
    input  req_valid, req_rd_en, req_wr_en, req_addr, req_wr_data, req_byte_en, req_sign_ext, rsp_ready,
    output req_ready, rsp_valid, rsp_rd_data, rsp_err
  );
endinterface

// File: rtl/rv_dmem_lane_align.sv
// rv_dmem_lane_align: store lane shift/mask and load extract/extend (combinational).
// RV_DMEM_MISALIGN_TRAP_EN: flag misaligned half/word accesses as faults instead of aligning down.
module rv_dmem_lane_align
  import rv_dmem_responder_pkg::*;
(
  input  t_dmem_req   req,
  input  logic [31:0] rd_word,
  output logic [3:0]  wr_mask,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data,
  output logic        fault
);
  logic [1:0]  off;
  logic [31:0] sh;
  always_comb begin
    off     = req.byte_en == DMEM_BE_WORD ? 2'd0 :
              req.byte_en == DMEM_BE_HALF ? {req.off[1], 1'b0} : req.off;
    wr_mask = req.byte_en << off;
    wr_word = req.wr_data << {off, 3'b000};
    sh      = rd_word >> {off, 3'b000};
    rd_data = req.byte_en == DMEM_BE_BYTE ? {{24{req.sign_ext & sh[7]}}, sh[7:0]} :
              req.byte_en == DMEM_BE_HALF ? {{16{req.sign_ext & sh[15]}}, sh[15:0]} : sh;
  end
`ifdef RV_DMEM_MISALIGN_TRAP_EN
  assign fault = (req.byte_en == DMEM_BE_HALF && req.off[0]) ||
                 (req.byte_en == DMEM_BE_WORD && req.off != 2'd0);
`else
  assign fault = 1'b0;
`endif
endmodule

// File: rtl/rv_dmem_responder.sv
// rv_dmem_responder: single-outstanding dmem slave with configurable read latency.
// Misaligned-access trapping is enabled by RV_DMEM_MISALIGN_TRAP_EN (see rv_dmem_lane_align).
module rv_dmem_responder
  import rv_dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 1
) (
  input logic clk,
  input logic rst_n,
  rv_dmem_responder_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  t_dmem_state state, state_nxt;
  logic [3:0]  cnt;
  t_dmem_rsp   rsp_q, rsp_d;
  t_dmem_req   req;
  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic [3:0]  wr_mask;
  logic [31:0] wr_word, rd_data;
  logic        accept, oor, be_ok, fault, err;
  assign req    = '{byte_en: bus.req_byte_en, sign_ext: bus.req_sign_ext,
                    off: bus.req_addr[1:0], wr_data: bus.req_wr_data};
  assign idx    = bus.req_addr[IW+1:2];
  assign oor    = (bus.req_addr >> (IW + 2)) != '0;
  assign be_ok  = bus.req_byte_en inside {DMEM_BE_BYTE, DMEM_BE_HALF, DMEM_BE_WORD};
  assign err    = (bus.req_rd_en & bus.req_wr_en) | ~be_ok | oor | fault;
  assign accept = bus.req_valid & (state == IDLE);
  assign rsp_d  = '{data: (err || !bus.req_rd_en) ? 32'd0 : rd_data, err: err};
  rv_dmem_lane_align u_align (
    .req     (req),
    .rd_word (mem[idx]),
    .wr_mask (wr_mask),
    .wr_word (wr_word),
    .rd_data (rd_data),
    .fault   (fault)
  );
  // Response register captures load data on the acceptance edge and holds it until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt   <= 4'(RD_LATENCY - 1);
        rsp_q <= rsp_d;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
    end
  end
  always_comb begin
    state_nxt = state == IDLE ? (accept ? (RD_LATENCY == 1 ? RESP : WAIT) : IDLE) :
                state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) :
                (bus.rsp_ready ? IDLE : RESP);
  end
  always_comb begin
    bus.req_ready   = state == IDLE;
    bus.rsp_valid   = state == RESP;
    bus.rsp_rd_data = rsp_q.data;
    bus.rsp_err     = rsp_q.err;
  end
  // Storage is not reset; stores commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && bus.req_wr_en && !err)
      for (int i = 0; i < 4; i++)
        if (wr_mask[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
  end
endmodule

// File: doc/rv_dmem_responder.md
Name: rv_dmem_responder

Overview:
Data-memory responder for the 5-stage RV core; it is the slave end of the MA-stage dmem request interface.
- Accepts one request at a time (read/write enables, byte enable, sign-extend flag, address, write data).
- Performs byte-lane alignment, masking and sign/zero extension internally.
- Returns exactly one response per accepted request after a configurable read latency, over a valid/ready handshake.

Parameters:
ADDR_W, 32, request address width
DEPTH_WORDS, 1024, storage depth in 32-bit words (power of 2)
RD_LATENCY, 1, cycles from acceptance edge to rsp_valid (legal range 1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept
req_rd_en  in  1  load request
req_wr_en  in  1  store request
req_addr  in  ADDR_W  byte address
req_wr_data  in  32  store data, right-justified (byte/half in low bits)
req_byte_en  in  4  unshifted size mask: 0001 byte, 0011 half, 1111 word
req_sign_ext  in  1  sign-extend load result (LB/LH)
rsp_valid  out  1  response present
rsp_ready  in  1  requester consumes response
rsp_rd_data  out  32  aligned, extended load data; 0 for stores and errors
rsp_err  out  1  access faulted; no memory side effect

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, rsp_valid=0, rsp_rd_data=0, rsp_err=0, latency counter=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Acceptance = req_valid & req_ready. On acceptance, load counter with RD_LATENCY-1. Go to RESP if RD_LATENCY=1, else WAIT.
  - WAIT: req_ready=0. Decrement counter. Go to RESP when counter reaches 0.
  - RESP: rsp_valid=1; rsp_rd_data/rsp_err held stable. On rsp_ready, go to IDLE next cycle. No same-cycle re-accept; minimum throughput is one access per 2 cycles.
- Stores commit to memory on the acceptance edge. Load data is read and extended on the acceptance edge and held in a response register.
- Lane rules: off = req_addr[1:0].
  - Store: effective byte mask = req_byte_en << off; data = req_wr_data << 8*off; only masked bytes are written.
  - Load: word >> 8*off, masked to size. Sign bit is bit 7 (byte) or bit 15 (half) when req_sign_ext=1, else zero-extend.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2].
- Errors: rsp_err=1, no write, rsp_rd_data=0 when any of the following holds:
  - rd_en and wr_en both set;
  - req_byte_en not in {0001,0011,1111};
  - any req_addr bit above the index range is set (out of range; no wrap-around).
- Neither enable set: request accepted, response is data 0, err 0.
- Reset during WAIT/RESP: the pending response is dropped; a store already committed remains in memory.

Optional Feature:
RV_DMEM_MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]≠0 gives rsp_err=1, no write, data 0.
- Undefined: misaligned offsets are aligned down. Word accesses ignore addr[1:0]; half accesses ignore addr[0]. No error is raised for misalignment.

Decomposition:
- rv_pkg additions:
  - t_dmem_state enum (IDLE/WAIT/RESP);
  - constants DMEM_BE_BYTE=4'b0001, DMEM_BE_HALF=4'b0011, DMEM_BE_WORD=4'b1111;
  - t_dmem_req / t_dmem_rsp structs.
- One sub-module: rv_dmem_lane_align. It is combinational and holds the store shift/mask generation plus load extract/extend. The FSM, counter and storage stay in the top module.

Test Plan:
- SW 0x12345678 @0x10, then LW @0x10 (RD_LATENCY=1) -> rsp_valid asserted 1 cycle after accept, data 0x12345678, err 0.
- SB 0x000000AB @0x11 over word 0x12345678, then LW @0x10 -> 0x1234AB78.
- Word 0x00008080 @0x20: LB @0x20 -> 0xFFFFFF80; LBU @0x20 -> 0x00000080; LH @0x20 -> 0xFFFF8080; LHU -> 0x00008080.
- RD_LATENCY=3, LW, rsp_ready low 4 cycles -> rsp_valid rises exactly 3 cycles after accept, data stable throughout, req_ready=0 until the handshake completes.
- LW @0x22: with RV_DMEM_MISALIGN_TRAP_EN -> err 1, data 0. Without it -> word @0x20 returned, err 0. SW @0x22 with the macro -> memory unchanged.
- Assert rst_n=0 during RESP -> rsp_valid=0 immediately, req_ready=1. Store accepted before reset is still readable afterwards. rd_en+wr_en together -> err 1, no write.
